// File: rtl/ppi_bus_sequencer.sv
// Two-requester sequencer for an 8255-style PPI: boots STATUS and CWR, then
// arbitrates round-robin and runs each access as SETUP/STROBE/HOLD phases.
module ppi_bus_sequencer #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 2,
  parameter logic [7:0]  STATUS_INIT = 8'h00,
  parameter logic [7:0]  CWR_INIT    = 8'hC2
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       req0_valid,
  input  logic       req0_wr,
  input  logic [2:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  output logic       req0_done,
  input  logic       req1_valid,
  input  logic       req1_wr,
  input  logic [2:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic       req1_done,
  output logic [7:0] rdata,
  output logic       ppi_rdb,
  output logic       ppi_wrb,
  output logic [2:0] ppi_address,
  output logic [7:0] ppi_data_out,
  output logic       ppi_data_oe,
  input  logic [7:0] ppi_data_in,
  output logic       init_done,
  output logic       busy
);

  typedef enum logic [2:0] {
    INIT_STATUS,
    INIT_CWR,
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam logic [2:0] STATUS_ADDR = 3'b111;
  localparam logic [2:0] CWR_ADDR    = 3'b011;

  // Counters hold "cycles remaining minus one"; a phase ends when it reads zero.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       txn_wr, wr_next;
  logic [2:0] addr_next;
  logic [7:0] wdata_next;
  logic       owner;
  logic       prefer1;
  logic       boot_cwr, boot_cwr_next;
  logic       init_done_next;
  logic       grant0, grant1;
  logic       done0_next, done1_next;
  logic       capture;
  logic       active_next;

  // NOTE: every signal written here gets a default first, so no path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    wr_next        = txn_wr;
    addr_next      = ppi_address;
    wdata_next     = ppi_data_out;
    boot_cwr_next  = boot_cwr;
    init_done_next = init_done;
    grant0         = 1'b0;
    grant1         = 1'b0;
    done0_next     = 1'b0;
    done1_next     = 1'b0;
    capture        = 1'b0;

    unique case (state)
      INIT_STATUS: begin
        state_next = SETUP;
        cnt_next   = SETUP_LD;
        wr_next    = 1'b1;
        addr_next  = STATUS_ADDR;
        wdata_next = STATUS_INIT;
      end

      INIT_CWR: begin
        state_next    = SETUP;
        cnt_next      = SETUP_LD;
        wr_next       = 1'b1;
        addr_next     = CWR_ADDR;
        wdata_next    = CWR_INIT;
        boot_cwr_next = 1'b1;
      end

      IDLE: begin
        // Round-robin: req0 wins unless req1 is also waiting and has the turn.
        if (init_done) begin
          if (req0_valid && (!req1_valid || !prefer1)) begin
            grant0 = 1'b1;
          end else if (req1_valid) begin
            grant1 = 1'b1;
          end
        end
        if (grant0) begin
          state_next = SETUP;
          cnt_next   = SETUP_LD;
          wr_next    = req0_wr;
          addr_next  = req0_addr;
          wdata_next = req0_wdata;
        end else if (grant1) begin
          state_next = SETUP;
          cnt_next   = SETUP_LD;
          wr_next    = req1_wr;
          addr_next  = req1_addr;
          wdata_next = req1_wdata;
        end
      end

      SETUP: begin
        if (cnt == 4'd0) begin
          state_next = STROBE;
          cnt_next   = STROBE_LD;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end

      STROBE: begin
        if (cnt == 4'd0) begin
          state_next = HOLD;
          cnt_next   = HOLD_LD;
          capture    = !txn_wr;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end

      HOLD: begin
        if (cnt == 4'd0) begin
          if (!init_done) begin
            if (boot_cwr) begin
              state_next     = IDLE;
              init_done_next = 1'b1;
            end else begin
              state_next = INIT_CWR;
            end
          end else begin
            state_next = IDLE;
            done0_next = !owner;
            done1_next = owner;
          end
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end

      default: state_next = INIT_STATUS;
    endcase
  end

  assign active_next = (state_next == SETUP) || (state_next == STROBE) || (state_next == HOLD);

  // Outputs are registered from the next-state decode so they line up with the state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state        <= INIT_STATUS;
      cnt          <= 4'd0;
      txn_wr       <= 1'b0;
      owner        <= 1'b0;
      prefer1      <= 1'b0;
      boot_cwr     <= 1'b0;
      init_done    <= 1'b0;
      busy         <= 1'b1;
      req0_ready   <= 1'b0;
      req1_ready   <= 1'b0;
      req0_done    <= 1'b0;
      req1_done    <= 1'b0;
      rdata        <= 8'h00;
      ppi_rdb      <= 1'b1;
      ppi_wrb      <= 1'b1;
      ppi_address  <= 3'b000;
      ppi_data_out <= 8'h00;
      ppi_data_oe  <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      txn_wr       <= wr_next;
      boot_cwr     <= boot_cwr_next;
      init_done    <= init_done_next;
      busy         <= (state_next != IDLE);
      req0_ready   <= grant0;
      req1_ready   <= grant1;
      req0_done    <= done0_next;
      req1_done    <= done1_next;
      ppi_address  <= addr_next;
      ppi_data_out <= wdata_next;
      ppi_data_oe  <= wr_next && active_next;
      ppi_wrb      <= !((state_next == STROBE) && wr_next);
      ppi_rdb      <= !((state_next == STROBE) && !wr_next);
      if (grant0) begin
        owner   <= 1'b0;
        prefer1 <= 1'b1;
      end else if (grant1) begin
        owner   <= 1'b1;
        prefer1 <= 1'b0;
      end
      if (capture) begin
        rdata <= ppi_data_in;
      end
    end
  end

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// Directed bench for ppi_bus_sequencer: boot writes, single accesses,
// round-robin arbitration, reset mid-strobe and requests held through boot.
module tb_ppi_bus_sequencer;

  logic       clk;
  logic       resetb;
  logic       req0_valid, req0_wr, req0_ready, req0_done;
  logic [2:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       req1_valid, req1_wr, req1_ready, req1_done;
  logic [2:0] req1_addr;
  logic [7:0] req1_wdata;
  logic [7:0] rdata;
  logic       ppi_rdb, ppi_wrb, ppi_data_oe;
  logic [2:0] ppi_address;
  logic [7:0] ppi_data_out;
  logic [7:0] ppi_data_in;
  logic       init_done, busy;
  logic [7:0] dev_data;

  int errors = 0;
  int checks = 0;

  int viol        = 0;
  int early_ready = 0;
  int done_count  = 0;
  int done_snap   = 0;

  int         o_who, o_wait, o_done_at, o_done_cnt, o_wrb, o_rdb, o_oe;
  logic [2:0] o_addr;
  logic [7:0] o_data, o_rdata;

  ppi_bus_sequencer dut (
    .clk          (clk),
    .resetb       (resetb),
    .req0_valid   (req0_valid),
    .req0_wr      (req0_wr),
    .req0_addr    (req0_addr),
    .req0_wdata   (req0_wdata),
    .req0_ready   (req0_ready),
    .req0_done    (req0_done),
    .req1_valid   (req1_valid),
    .req1_wr      (req1_wr),
    .req1_addr    (req1_addr),
    .req1_wdata   (req1_wdata),
    .req1_ready   (req1_ready),
    .req1_done    (req1_done),
    .rdata        (rdata),
    .ppi_rdb      (ppi_rdb),
    .ppi_wrb      (ppi_wrb),
    .ppi_address  (ppi_address),
    .ppi_data_out (ppi_data_out),
    .ppi_data_oe  (ppi_data_oe),
    .ppi_data_in  (ppi_data_in),
    .init_done    (init_done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Device only drives valid data while it is being read.
  always_comb ppi_data_in = ppi_rdb ? 8'hEE : dev_data;

  always @(negedge clk) begin
    if (resetb) begin
      if (!ppi_rdb && !ppi_wrb) viol++;
      if (ppi_data_oe && !ppi_rdb) viol++;
      if (!init_done && (req0_ready || req1_ready)) early_ready++;
      if (req0_done || req1_done) done_count++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Wait for the next strobe and measure it.
  task automatic wait_strobe(output logic is_wr, output logic [2:0] a, output logic [7:0] d,
                             output int len, output bit ok);
    int n;
    n = 0; ok = 1'b0; len = 0; is_wr = 1'b0; a = '0; d = '0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (!ppi_wrb || !ppi_rdb) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      is_wr = !ppi_wrb;
      a     = ppi_address;
      d     = ppi_data_out;
      while (len < 20 && (is_wr ? !ppi_wrb : !ppi_rdb)) begin
        len++;
        @(negedge clk);
      end
    end
  endtask

  // Wait for a ready pulse, then sample the nine cycles from ready to done.
  task automatic observe(input bit drop);
    o_who = -1; o_wait = 0; o_done_at = -1; o_done_cnt = 0;
    o_wrb = 0; o_rdb = 0; o_oe = 0; o_addr = '0; o_data = '0; o_rdata = '0;
    do begin
      @(negedge clk);
      o_wait++;
    end while (!(req0_ready || req1_ready) && o_wait < 50);
    if (!(req0_ready || req1_ready)) return;
    o_who = (req0_ready && req1_ready) ? 2 : (req0_ready ? 0 : 1);
    if (drop) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge clk);
      if (!ppi_wrb) begin
        o_wrb++;
        o_addr = ppi_address;
        o_data = ppi_data_out;
      end
      if (!ppi_rdb) begin
        o_rdb++;
        o_addr = ppi_address;
      end
      if (ppi_data_oe) o_oe++;
      if (req0_done) o_done_cnt++;
      if (req1_done) o_done_cnt++;
      if ((o_who == 0 && req0_done) || (o_who == 1 && req1_done)) begin
        o_done_at = k;
        o_rdata   = rdata;
      end
    end
  endtask

  task automatic test_reset;
    resetb = 1'b0;
    req0_valid = 0; req0_wr = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_wr = 0; req1_addr = 0; req1_wdata = 0;
    dev_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if ({ppi_rdb, ppi_wrb, ppi_data_oe} !== 3'b110) begin errors++; $display("FAIL reset_strobes: got %b want 110", {ppi_rdb, ppi_wrb, ppi_data_oe}); end
    checks++; if ({ppi_address, ppi_data_out} !== 11'd0) begin errors++; $display("FAIL reset_bus: got addr %h data %h want 0 0", ppi_address, ppi_data_out); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    checks++; if ({req0_ready, req1_ready, req0_done, req1_done} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {req0_ready, req1_ready, req0_done, req1_done}); end
    checks++; if ({init_done, busy} !== 2'b01) begin errors++; $display("FAIL reset_status: got init_done/busy %b want 01", {init_done, busy}); end
    resetb = 1'b1;
  endtask

  task automatic test_boot;
    logic is_wr;
    logic [2:0] a;
    logic [7:0] d;
    int len, n;
    bit ok;
    wait_strobe(is_wr, a, d, len, ok);
    checks++; if ({ok, is_wr} !== 2'b11) begin errors++; $display("FAIL boot_status_write: got ok/wr %b want 11", {ok, is_wr}); end
    checks++; if ({a, d} !== {3'b111, 8'h00}) begin errors++; $display("FAIL boot_status_addr_data: got %h %h want 7 00", a, d); end
    checks++; if (len !== 4) begin errors++; $display("FAIL boot_status_len: got %0d want 4", len); end
    wait_strobe(is_wr, a, d, len, ok);
    checks++; if ({ok, is_wr} !== 2'b11) begin errors++; $display("FAIL boot_cwr_write: got ok/wr %b want 11", {ok, is_wr}); end
    checks++; if ({a, d} !== {3'b011, 8'hC2}) begin errors++; $display("FAIL boot_cwr_addr_data: got %h %h want 3 c2", a, d); end
    checks++; if (len !== 4) begin errors++; $display("FAIL boot_cwr_len: got %0d want 4", len); end
    n = 0;
    while (!init_done && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL boot_init_done: got %b want 1", init_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL boot_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_write;
    req0_valid = 1; req0_wr = 1; req0_addr = 3'b001; req0_wdata = 8'h67;
    observe(1'b1);
    checks++; if (o_who !== 0) begin errors++; $display("FAIL write_who: got %0d want 0", o_who); end
    checks++; if (o_wait !== 1) begin errors++; $display("FAIL write_accept_wait: got %0d want 1", o_wait); end
    checks++; if ({o_wrb, o_rdb} !== {32'd4, 32'd0}) begin errors++; $display("FAIL write_strobe_len: got wrb %0d rdb %0d want 4 0", o_wrb, o_rdb); end
    checks++; if ({o_addr, o_data} !== {3'b001, 8'h67}) begin errors++; $display("FAIL write_addr_data: got %h %h want 1 67", o_addr, o_data); end
    checks++; if (o_oe !== 8) begin errors++; $display("FAIL write_oe_cycles: got %0d want 8", o_oe); end
    checks++; if ({o_done_cnt, o_done_at} !== {32'd1, 32'd8}) begin errors++; $display("FAIL write_done: got count %0d at %0d want 1 at 8", o_done_cnt, o_done_at); end
  endtask

  task automatic test_read;
    dev_data = 8'h3C;
    req0_valid = 1; req0_wr = 0; req0_addr = 3'b110;
    observe(1'b1);
    checks++; if ({o_who, o_done_at} !== {32'd0, 32'd8}) begin errors++; $display("FAIL read0_who_done: got %0d at %0d want 0 at 8", o_who, o_done_at); end
    checks++; if ({o_addr, o_rdata} !== {3'b110, 8'h3C}) begin errors++; $display("FAIL read0_addr_rdata: got %h %h want 6 3c", o_addr, o_rdata); end
    dev_data = 8'hA5;
    req1_valid = 1; req1_wr = 0; req1_addr = 3'b000;
    observe(1'b1);
    checks++; if (o_who !== 1) begin errors++; $display("FAIL read1_who: got %0d want 1", o_who); end
    checks++; if ({o_rdb, o_wrb} !== {32'd4, 32'd0}) begin errors++; $display("FAIL read1_strobe_len: got rdb %0d wrb %0d want 4 0", o_rdb, o_wrb); end
    checks++; if (o_oe !== 0) begin errors++; $display("FAIL read1_oe_cycles: got %0d want 0", o_oe); end
    checks++; if (o_addr !== 3'b000) begin errors++; $display("FAIL read1_addr: got %h want 0", o_addr); end
    checks++; if ({o_done_cnt, o_done_at} !== {32'd1, 32'd8}) begin errors++; $display("FAIL read1_done: got count %0d at %0d want 1 at 8", o_done_cnt, o_done_at); end
    checks++; if (o_rdata !== 8'hA5) begin errors++; $display("FAIL read1_rdata: got %h want a5", o_rdata); end
  endtask

  task automatic test_round_robin;
    int exp_who[3]   = '{0, 1, 0};
    logic [7:0] exp_d[3] = '{8'h10, 8'h20, 8'h10};
    bit stray;
    req0_valid = 1; req0_wr = 1; req0_addr = 3'b100; req0_wdata = 8'h10;
    req1_valid = 1; req1_wr = 1; req1_addr = 3'b101; req1_wdata = 8'h20;
    for (int g = 0; g < 3; g++) begin
      observe(1'b0);
      checks++; if (o_who !== exp_who[g]) begin errors++; $display("FAIL rr_grant%0d_who: got %0d want %0d", g, o_who, exp_who[g]); end
      checks++; if (o_wait !== 1) begin errors++; $display("FAIL rr_grant%0d_spacing: got %0d want 1", g, o_wait); end
      checks++; if ({o_data, o_done_at} !== {exp_d[g], 32'd8}) begin errors++; $display("FAIL rr_grant%0d_data_done: got %h at %0d want %h at 8", g, o_data, o_done_at, exp_d[g]); end
    end
    req0_valid = 0;
    req1_valid = 0;
    stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (req0_ready || req1_ready) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL rr_no_extra_grant: got %b want 0", stray); end
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL rr_rdata_held: got %h want a5", rdata); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL rr_strobe_overlap: got %0d want 0", viol); end
  endtask

  task automatic test_single;
    req0_valid = 1; req0_wr = 1; req0_addr = 3'b010; req0_wdata = 8'h33;
    observe(1'b1);
    checks++; if ({o_who, o_wait} !== {32'd0, 32'd1}) begin errors++; $display("FAIL single_grant: got who %0d wait %0d want 0 1", o_who, o_wait); end
    checks++; if ({o_addr, o_data} !== {3'b010, 8'h33}) begin errors++; $display("FAIL single_addr_data: got %h %h want 2 33", o_addr, o_data); end
  endtask

  task automatic test_reset_mid_strobe;
    int n;
    req0_valid = 1; req0_wr = 1; req0_addr = 3'b010; req0_wdata = 8'h99;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req0_ready && n < 30);
    req0_valid = 0;
    n = 0;
    while (ppi_wrb && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++; if (ppi_wrb !== 1'b0) begin errors++; $display("FAIL midrst_reached_strobe: got wrb %b want 0", ppi_wrb); end
    @(negedge clk);
    done_snap = done_count;
    #2 resetb = 1'b0;
    #1;
    checks++; if ({ppi_rdb, ppi_wrb, ppi_data_oe} !== 3'b110) begin errors++; $display("FAIL midrst_strobes: got %b want 110", {ppi_rdb, ppi_wrb, ppi_data_oe}); end
    checks++; if ({init_done, busy, ppi_address} !== {2'b01, 3'b000}) begin errors++; $display("FAIL midrst_status: got %b want 01000", {init_done, busy, ppi_address}); end
    req0_valid = 1; req0_wr = 1; req0_addr = 3'b101; req0_wdata = 8'h11;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
  endtask

  task automatic test_request_during_boot;
    checks++; if (done_count !== done_snap) begin errors++; $display("FAIL boot_no_done_after_abort: got %0d want %0d", done_count, done_snap); end
    checks++; if (early_ready !== 0) begin errors++; $display("FAIL boot_ready_gated: got %0d want 0", early_ready); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL boot_first_idle_ready: got %b want 0", req0_ready); end
    observe(1'b1);
    checks++; if ({o_who, o_wait} !== {32'd0, 32'd1}) begin errors++; $display("FAIL boot_pending_accept: got who %0d wait %0d want 0 1", o_who, o_wait); end
    checks++; if ({o_addr, o_data} !== {3'b101, 8'h11}) begin errors++; $display("FAIL boot_pending_addr_data: got %h %h want 5 11", o_addr, o_data); end
    checks++; if ({o_wrb, o_done_at} !== {32'd4, 32'd8}) begin errors++; $display("FAIL boot_pending_txn: got wrb %0d done at %0d want 4 8", o_wrb, o_done_at); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL final_strobe_overlap: got %0d want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_write();
    test_read();
    test_round_robin();
    test_single();
    test_reset_mid_strobe();
    test_boot();
    test_request_during_boot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
